spi_boot_slave: RTL and testbench

- SPI mode-0 slave: the responder at the far end of the boot-image SPI link that the chip's SPI loader masters.
- Oversamples spi_clk, mosi and ss in the clk domain.
- Decodes READ (0x03) and READ-ID (0x9F) commands and streams bytes from a byte-wide synchronous memory read port, MSB first.
- Used as the on-board/FPGA boot-image server and as the synthesizable loader bench partner.

---
 rtl/spi_boot_slave.sv | 211 +++++++++++++++++++++
 tb/tb_spi_boot_slave.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_slave.sv
// SPI mode-0 boot-image server: decodes READ (0x03) / READ-ID (0x9F) and streams bytes MSB first.
// spi_clk/mosi/ss cross into clk via 2-flop syncs; miso updates within 4 clk of the fall; no backpressure.
module spi_boot_slave #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [7:0]  ID_BYTE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  active,
    output logic                  cmd_err
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_FIRST,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    logic [2:0]            sclk_q;
    logic [1:0]            mosi_q;
    logic [1:0]            ss_q;
    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-2:0] addr_q, addr_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            pf_q, pf_d;
    logic                  miso_q, miso_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  rd_vld_q;

    logic                  rise, fall, mosi_s, ss_s;
    logic [7:0]            cmd_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign ss_s      = ss_q[1];
    assign cmd_next  = {cmd_q, mosi_s};
    assign addr_next = {addr_q, mosi_s};

    // ss sync resets high so active and the FSM stay quiet coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            ss_q   <= 2'b11;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], mosi};
            ss_q   <= {ss_q[0], ss};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            tx_q       <= '0;
            pf_q       <= '0;
            miso_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cmd_err_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            pf_q       <= pf_d;
            miso_q     <= miso_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cmd_err_q  <= cmd_err_d;
            rd_vld_q   <= mem_rd_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        pf_d       = pf_q;
        miso_d     = miso_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        cmd_err_d  = 1'b0;

        // Deselect wins over any edge seen in the same cycle.
        if (ss_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            cmd_d     = '0;
            addr_d    = '0;
            tx_d      = '0;
            pf_d      = '0;
            miso_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end
                S_CMD: begin
                    if (rise) begin
                        cmd_d     = cmd_next[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            case (cmd_next)
                                8'h03:   state_d = S_ADDR;
                                8'h9F: begin
                                    state_d = S_ID;
                                    tx_d    = ID_BYTE;
                                end
                                default: begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        addr_d    = addr_next[ADDR_WIDTH-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_next;
                            state_d    = S_FIRST;
                        end
                    end
                end
                S_FIRST: begin
                    // First byte lands here; the prefetch of the next byte goes out at once.
                    if (rd_vld_q) begin
                        tx_d       = mem_rdata;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                        state_d    = S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_vld_q) begin
                        pf_d = mem_rdata;
                    end
                    if (fall) begin
                        miso_d    = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = '0;
                            tx_d       = pf_q;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + ADDR_ONE;
                        end
                    end
                end
                S_ID: begin
                    if (fall) begin
                        miso_d    = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            tx_d      = ID_BYTE;
                        end
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign active   = ~ss_s;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_boot_slave.sv
// Bench for spi_boot_slave: a mode-0 SPI master with randomized phase lengths drives transactions;
// miso bytes, read strobes and cmd_err pulses are compared against a byte-level model.
module tb_spi_boot_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        mosi;
    logic        ss;
    logic        miso;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        active;
    logic        cmd_err;

    always #5 clk = ~clk;

    spi_boot_slave #(.ADDR_WIDTH(16), .ID_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .ss        (ss),
        .miso      (miso),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .active    (active),
        .cmd_err   (cmd_err)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic        tx_bits[$];
    logic        sent_bits[$];
    logic        rx_bits[$];
    logic [15:0] rd_q[$];
    int          err_pulses  = 0;
    int          rd_back2back = 0;
    logic        rd_prev     = 1'b0;
    int          hmin = 4;
    int          hmax = 6;

    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (mem_rd && rd_prev) rd_back2back++;
        rd_prev = mem_rd;
        if (cmd_err) err_pulses++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        tx_bits.delete();
        sent_bits.delete();
        rx_bits.delete();
        rd_q.delete();
        err_pulses = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endtask

    task automatic begin_txn(input string tag);
        clear_model();
        ss = 1'b0;
        wait_clk(hmax + 3);
        check_eq({tag, "_active"}, {31'b0, active}, 32'd1);
    endtask

    task automatic run_bits(input int n);
        for (int k = 0; k < n; k++) begin
            mosi = (tx_bits.size() != 0) ? tx_bits.pop_front() : 1'($urandom_range(0, 1));
            sent_bits.push_back(mosi);
            wait_clk($urandom_range(hmin, hmax));
            rx_bits.push_back(miso);
            spi_clk = 1'b1;
            wait_clk($urandom_range(hmin, hmax));
            spi_clk = 1'b0;
        end
    endtask

    task automatic end_txn(input string tag);
        wait_clk(hmax);
        ss = 1'b1;
        wait_clk(4);
        check_eq({tag, "_idle"}, {30'b0, active, miso}, 32'd0);
    endtask

    // Bit the master should see at 0-based rise i, from the command/address it sent.
    function automatic logic exp_bit(input int i, input logic [7:0] cmd, input logic [15:0] a);
        logic [7:0] b;
        int         j;
        if (i < 8) return 1'b0;
        if (cmd == 8'h03) begin
            if (i < 32) return 1'b0;
            j = i - 32;
            b = mem[a + 16'(j / 8)];
            return b[7 - (j % 8)];
        end
        if (cmd == 8'h9F) begin
            j = i - 8;
            b = 8'hA5;
            return b[7 - (j % 8)];
        end
        return 1'b0;
    endfunction

    task automatic verify(input string tag);
        int          n;
        int          nexp;
        int          eerr;
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [7:0]  eb;
        logic [7:0]  ob;
        n   = sent_bits.size();
        cmd = 8'h00;
        a   = 16'h0000;
        for (int i = 0; i < 8 && i < n; i++) cmd = {cmd[6:0], sent_bits[i]};
        for (int i = 16; i < 32 && i < n; i++) a = {a[14:0], sent_bits[i]};
        for (int c = 0; c < n; c += 8) begin
            eb = '0;
            ob = '0;
            for (int k = c; k < c + 8 && k < n; k++) begin
                eb = {eb[6:0], exp_bit(k, cmd, a)};
                ob = {ob[6:0], rx_bits[k]};
            end
            check_eq($sformatf("%s_miso_b%0d", tag, c / 8), {24'b0, ob}, {24'b0, eb});
        end
        // Initial fetch + prefetch, then one more per byte completed after the 32nd rise's fall.
        nexp = (n >= 32 && cmd == 8'h03) ? 2 + (n - 31) / 8 : 0;
        check_eq({tag, "_nrd"}, rd_q.size(), nexp);
        for (int i = 0; i < nexp && i < rd_q.size(); i++)
            check_eq($sformatf("%s_rd%0d", tag, i), {16'b0, rd_q[i]}, {16'b0, a + 16'(i)});
        eerr = (n >= 8 && cmd != 8'h03 && cmd != 8'h9F) ? 1 : 0;
        check_eq({tag, "_cmd_err"}, err_pulses, eerr);
    endtask

    task automatic do_read(input string tag, input logic [23:0] addr, input int nbits);
        begin_txn(tag);
        push_byte(8'h03);
        push_byte(addr[23:16]);
        push_byte(addr[15:8]);
        push_byte(addr[7:0]);
        run_bits(nbits);
        end_txn(tag);
        verify(tag);
    endtask

    initial begin
        int          viol;
        logic [31:0] word;
        logic [7:0]  rc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        mem[16'h0103] = 8'h44;

        reset   = 1'b0;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        ss      = 1'b1;
        viol    = 0;
        wait_clk(2);
        ss = 1'b0;
        for (int i = 0; i < 40; i++) begin
            spi_clk = ~spi_clk;
            mosi    = 1'($urandom_range(0, 1));
            wait_clk(2);
            if (miso || mem_rd || active || cmd_err) viol++;
        end
        check_eq("rst_quiet", viol, 0);
        spi_clk = 1'b0;
        ss      = 1'b1;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(5);
        check_eq("rst_outputs", {13'b0, mem_addr, miso, mem_rd, active, cmd_err}, 32'd0);

        do_read("basic", 24'h000100, 64);
        word = '0;
        for (int i = 32; i < 64; i++) word = {word[30:0], rx_bits[i]};
        check_eq("basic_word", word, 32'h11223344);

        do_read("wrap", 24'hABFFFE, 64);

        begin_txn("id");
        push_byte(8'h9F);
        run_bits(32);
        end_txn("id");
        verify("id");

        begin_txn("bad");
        push_byte(8'h5A);
        run_bits(24);
        end_txn("bad");
        verify("bad");
        do_read("after_bad", 24'h001234, 48);

        do_read("abort_addr", 24'h00ABCD, 20);
        do_read("after_abort", 24'h000010, 56);
        do_read("abort_data", 24'h004000, 45);
        do_read("after_abort2", 24'h000010, 48);

        hmin = 4;
        hmax = 4;
        do_read("min_abort", 24'h007777, 39);
        do_read("min_read", 24'h000010, 64);
        hmin = 4;
        hmax = 6;

        for (int t = 0; t < 6; t++) begin
            begin_txn($sformatf("rnd%0d", t));
            case ($urandom_range(0, 2))
                0:       rc = 8'h03;
                1:       rc = 8'h9F;
                default: rc = 8'($urandom);
            endcase
            push_byte(rc);
            push_byte(8'($urandom));
            push_byte(8'($urandom));
            push_byte(8'($urandom));
            run_bits($urandom_range(4, 72));
            end_txn($sformatf("rnd%0d", t));
            verify($sformatf("rnd%0d", t));
        end

        begin_txn("mid_rst");
        push_byte(8'h03);
        push_byte(8'h00);
        push_byte(8'h0F);
        push_byte(8'hF0);
        run_bits(42);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_out", {13'b0, mem_addr, miso, mem_rd, active, cmd_err}, 32'd0);
        wait_clk(3);
        reset = 1'b1;
        wait_clk(hmax + 4);
        clear_model();
        push_byte(8'h03);
        push_byte(8'h00);
        push_byte(8'h20);
        push_byte(8'h00);
        run_bits(48);
        end_txn("mid_rst");
        verify("mid_rst");

        check_eq("rd_back2back", rd_back2back, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
